// File: rtl/wb_arbiter_rr_pkg.sv
// rtl/wb_arbiter_rr_pkg.sv - shared types and constants for the Wishbone round-robin arbiter
// Purpose: FSM state type, priority-mode selectors, cycle/burst type encodings
//          and the pointer-width helper used by the arbiter and its picker.
// Ports:   none (package).
package wb_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        OWNED = 1'b1
    } arb_state_e;

    localparam int PRIO_RR    = 0;
    localparam int PRIO_FIXED = 1;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;

    localparam logic [1:0] BTE_LINEAR  = 2'b00;

    // A single master still needs a 1-bit pointer so every vector has a legal width.
    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/wb_arbiter_rr_if.sv
// rtl/wb_arbiter_rr_if.sv - bus bundle between the masters, the arbiter and the slave
// Purpose: groups the per-master request/termination signals, the single
//          slave-side bus and the grant/busy status.
// Ports (signals):
//   m_cyc/m_stb/m_we [MASTERS], m_adr, m_dat_m2s, m_sel, m_cti, m_bte per master
//   m_dat_s2m broadcast read data, m_ack/m_err/m_rty [MASTERS]
//   s_cyc/s_stb/s_we, s_adr, s_dat_m2s, s_sel, s_cti, s_bte to the slave
//   s_dat_s2m, s_ack/s_err/s_rty from the slave
//   grant [MASTERS] registered one-hot owner, busy
// Modports: master (requesters), slave (downstream device), arb (the arbiter).
interface wb_arbiter_rr_if #(
    parameter int MASTERS    = 3,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    localparam int SEL_WIDTH = DATA_WIDTH / 8;

    logic [MASTERS-1:0]                 m_cyc;
    logic [MASTERS-1:0]                 m_stb;
    logic [MASTERS-1:0]                 m_we;
    logic [MASTERS-1:0][ADDR_WIDTH-1:0] m_adr;
    logic [MASTERS-1:0][DATA_WIDTH-1:0] m_dat_m2s;
    logic [MASTERS-1:0][SEL_WIDTH-1:0]  m_sel;
    logic [MASTERS-1:0][2:0]            m_cti;
    logic [MASTERS-1:0][1:0]            m_bte;
    logic [DATA_WIDTH-1:0]              m_dat_s2m;
    logic [MASTERS-1:0]                 m_ack;
    logic [MASTERS-1:0]                 m_err;
    logic [MASTERS-1:0]                 m_rty;

    logic                               s_cyc;
    logic                               s_stb;
    logic                               s_we;
    logic [ADDR_WIDTH-1:0]              s_adr;
    logic [DATA_WIDTH-1:0]              s_dat_m2s;
    logic [SEL_WIDTH-1:0]               s_sel;
    logic [2:0]                         s_cti;
    logic [1:0]                         s_bte;
    logic [DATA_WIDTH-1:0]              s_dat_s2m;
    logic                               s_ack;
    logic                               s_err;
    logic                               s_rty;

    logic [MASTERS-1:0]                 grant;
    logic                               busy;

    modport master (
        output m_cyc, m_stb, m_we, m_adr, m_dat_m2s, m_sel, m_cti, m_bte,
        input  m_dat_s2m, m_ack, m_err, m_rty, grant, busy
    );

    modport slave (
        input  s_cyc, s_stb, s_we, s_adr, s_dat_m2s, s_sel, s_cti, s_bte,
        output s_dat_s2m, s_ack, s_err, s_rty
    );

    modport arb (
        input  m_cyc, m_stb, m_we, m_adr, m_dat_m2s, m_sel, m_cti, m_bte,
        output m_dat_s2m, m_ack, m_err, m_rty,
        output s_cyc, s_stb, s_we, s_adr, s_dat_m2s, s_sel, s_cti, s_bte,
        input  s_dat_s2m, s_ack, s_err, s_rty,
        output grant, busy
    );

endinterface

// File: rtl/wb_arbiter_rr_pick.sv
// rtl/wb_arbiter_rr_pick.sv - combinational rotate-priority encoder (module wb_arb_pick)
// Purpose: returns the first requester at or above the start index, wrapping
//          from MASTERS-1 to 0. Start is ptr_i in round-robin, 0 in fixed mode.
// Ports:
//   req_i    [MASTERS] request vector
//   ptr_i    [PTR_W]   round-robin start index
//   mode_i   1         0 = round-robin, 1 = fixed (lowest index wins)
//   winner_o [MASTERS] one-hot winner (zero when no request)
//   valid_o  1         at least one request present
module wb_arb_pick #(
    parameter int MASTERS = 3,
    parameter int PTR_W   = 2
) (
    input  logic [MASTERS-1:0] req_i,
    input  logic [PTR_W-1:0]   ptr_i,
    input  logic               mode_i,
    output logic [MASTERS-1:0] winner_o,
    output logic               valid_o
);

    int start_idx;
    int idx;

    always_comb begin
        winner_o  = '0;
        valid_o   = 1'b0;
        start_idx = mode_i ? 0 : int'(ptr_i);
        idx       = 0;
        // A pointer beyond the last master cannot come from the arbiter, but
        // clamp it so the search always covers every index exactly once.
        if (start_idx >= MASTERS) begin
            start_idx = 0;
        end
        for (int i = 0; i < MASTERS; i++) begin
            idx = start_idx + i;
            if (idx >= MASTERS) begin
                idx = idx - MASTERS;
            end
            if (!valid_o && req_i[idx]) begin
                winner_o[idx] = 1'b1;
                valid_o       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/wb_arbiter_rr.sv
// rtl/wb_arbiter_rr.sv - Wishbone B3 multi-master arbiter, round-robin or fixed priority
// Purpose: funnels MASTERS requesters onto one slave bus. Ownership is granted
//          from IDLE, held for as long as the owner keeps m_cyc high (burst
//          lock), and released through exactly one IDLE cycle.
// Optional: WB_ARB_TIMEOUT_EN adds a bus watchdog that terminates an owner
//           with a one-cycle m_err after TIMEOUT_CYCLES stalled strobes.
// Ports:
//   clk  bus clock
//   rst  synchronous active-high reset
//   bus  wb_arbiter_rr_if.arb: master-side requests/terminations, slave-side
//        bus, registered one-hot grant and busy
module wb_arbiter_rr
    import wb_arb_pkg::*;
#(
    parameter int MASTERS        = 3,
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int PRIORITY_MODE  = PRIO_RR,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic           clk,
    input  logic           rst,
    wb_arbiter_rr_if.arb   bus
);

    localparam int SEL_WIDTH = DATA_WIDTH / 8;
    localparam int PTR_W     = ptr_width(MASTERS);

    arb_state_e            state_q, state_d;
    logic [MASTERS-1:0]    grant_q, grant_d;
    logic [PTR_W-1:0]      ptr_q, ptr_d;

    logic [MASTERS-1:0]    win_oh;
    logic                  win_valid;
    logic [PTR_W-1:0]      win_idx;

    logic                  owner_cyc;
    logic                  owner_stb;
    logic                  owner_we;
    logic [ADDR_WIDTH-1:0] owner_adr;
    logic [DATA_WIDTH-1:0] owner_dat;
    logic [SEL_WIDTH-1:0]  owner_sel;
    logic [2:0]            owner_cti;
    logic [1:0]            owner_bte;

    logic                  fire;

    wb_arb_pick #(
        .MASTERS (MASTERS),
        .PTR_W   (PTR_W)
    ) u_pick (
        .req_i    (bus.m_cyc),
        .ptr_i    (ptr_q),
        .mode_i   (PRIORITY_MODE == PRIO_FIXED),
        .winner_o (win_oh),
        .valid_o  (win_valid)
    );

    always_comb begin
        win_idx = '0;
        for (int i = 0; i < MASTERS; i++) begin
            if (win_oh[i]) begin
                win_idx = PTR_W'(i);
            end
        end
    end

    // AND-OR mux keyed by the registered grant; grant is zero in IDLE, so the
    // slave side is quiet there without a separate state check.
    always_comb begin
        owner_adr = '0;
        owner_dat = '0;
        owner_sel = '0;
        owner_cti = '0;
        owner_bte = '0;
        for (int i = 0; i < MASTERS; i++) begin
            if (grant_q[i]) begin
                owner_adr = owner_adr | bus.m_adr[i];
                owner_dat = owner_dat | bus.m_dat_m2s[i];
                owner_sel = owner_sel | bus.m_sel[i];
                owner_cti = owner_cti | bus.m_cti[i];
                owner_bte = owner_bte | bus.m_bte[i];
            end
        end
    end

    assign owner_cyc = |(bus.m_cyc & grant_q);
    assign owner_stb = |(bus.m_stb & grant_q);
    assign owner_we  = |(bus.m_we  & grant_q);

`ifdef WB_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] wd_cnt_q, wd_cnt_d;
    logic             stalled;

    // Counts strobed cycles without any termination; the cycle that would
    // make the count reach TIMEOUT_CYCLES is the one that fires.
    assign stalled = (state_q == OWNED) && owner_cyc && owner_stb
                     && !(bus.s_ack || bus.s_err || bus.s_rty);
    assign fire    = stalled && (wd_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        wd_cnt_d = '0;
        if (stalled && !fire) begin
            wd_cnt_d = wd_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wd_cnt_q <= '0;
        end else begin
            wd_cnt_q <= wd_cnt_d;
        end
    end
`else
    logic unused_timeout;

    assign fire           = 1'b0;
    assign unused_timeout = (TIMEOUT_CYCLES == 0);
`endif

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        case (state_q)
            IDLE: begin
                if (win_valid) begin
                    state_d = OWNED;
                    grant_d = win_oh;
                    if (PRIORITY_MODE != PRIO_FIXED) begin
                        if (int'(win_idx) == MASTERS - 1) begin
                            ptr_d = '0;
                        end else begin
                            ptr_d = win_idx + PTR_W'(1);
                        end
                    end
                end
            end
            OWNED: begin
                // Burst lock: only the owner dropping cyc (or the watchdog)
                // ends ownership; other requests wait for the IDLE cycle.
                if (!owner_cyc || fire) begin
                    state_d = IDLE;
                    grant_d = '0;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
        end
    end

    assign bus.s_cyc     = owner_cyc & ~fire;
    assign bus.s_stb     = owner_stb & ~fire;
    assign bus.s_we      = owner_we;
    assign bus.s_adr     = owner_adr;
    assign bus.s_dat_m2s = owner_dat;
    assign bus.s_sel     = owner_sel;
    assign bus.s_cti     = owner_cti;
    assign bus.s_bte     = owner_bte;

    assign bus.m_dat_s2m = bus.s_dat_s2m;
    assign bus.m_ack     = grant_q & {MASTERS{bus.s_ack}};
    assign bus.m_err     = grant_q & {MASTERS{bus.s_err | fire}};
    assign bus.m_rty     = grant_q & {MASTERS{bus.s_rty}};

    assign bus.grant     = grant_q;
    assign bus.busy      = |grant_q;

endmodule

// File: tb/tb_wb_arbiter_rr.sv
// tb/tb_wb_arbiter_rr.sv - directed self-checking bench for wb_arbiter_rr
module tb_wb_arbiter_rr;
    import wb_arb_pkg::*;

    localparam int M  = 3;
    localparam int AW = 32;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    wb_arbiter_rr_if #(.MASTERS(M), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) ra ();
    wb_arbiter_rr_if #(.MASTERS(M), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) fx ();

    wb_arbiter_rr #(
        .MASTERS(M), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
        .PRIORITY_MODE(PRIO_RR), .TIMEOUT_CYCLES(8)
    ) u_rr (
        .clk (clk),
        .rst (rst),
        .bus (ra)
    );

    wb_arbiter_rr #(
        .MASTERS(M), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
        .PRIORITY_MODE(PRIO_FIXED), .TIMEOUT_CYCLES(8)
    ) u_fx (
        .clk (clk),
        .rst (rst),
        .bus (fx)
    );

    int n_err = 0;
    int n_chk = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [2:0] exp_g [4];
    logic [2:0] cti_seq [4];

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

    initial begin
        exp_g[0] = 3'b001; exp_g[1] = 3'b010; exp_g[2] = 3'b100; exp_g[3] = 3'b001;
        cti_seq[0] = CTI_INCR; cti_seq[1] = CTI_INCR; cti_seq[2] = CTI_INCR; cti_seq[3] = CTI_EOB;

        ra.m_cyc = '0; ra.m_stb = '0; ra.m_we = '0; ra.m_adr = '0; ra.m_dat_m2s = '0;
        ra.m_sel = '0; ra.m_cti = '0; ra.m_bte = '0;
        ra.s_dat_s2m = '0; ra.s_ack = 1'b0; ra.s_err = 1'b0; ra.s_rty = 1'b0;
        fx.m_cyc = '0; fx.m_stb = '0; fx.m_we = '0; fx.m_adr = '0; fx.m_dat_m2s = '0;
        fx.m_sel = '0; fx.m_cti = '0; fx.m_bte = '0;
        fx.s_dat_s2m = '0; fx.s_ack = 1'b0; fx.s_err = 1'b0; fx.s_rty = 1'b0;

        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_grant", ra.grant, 0);
        chk("rst_busy", ra.busy, 0);
        chk("rst_s_cyc", ra.s_cyc, 0);
        chk("rst_fx_grant", fx.grant, 0);

        // Single master, single beat
        ra.m_cyc = 3'b001; ra.m_stb = 3'b001; ra.m_we = 3'b001;
        ra.m_adr[0] = 32'h1000_0040; ra.m_dat_m2s[0] = 32'hCAFE_0001; ra.m_sel[0] = 4'hF;
        ra.s_dat_s2m = 32'h5A5A_0001;
        #1;
        chk("t1_idle_s_cyc", ra.s_cyc, 0);
        chk("t1_bcast_dat", ra.m_dat_s2m, 32'h5A5A_0001);
        tick();
        chk("t1_grant", ra.grant, 3'b001);
        chk("t1_busy", ra.busy, 1);
        chk("t1_s_cyc", ra.s_cyc, 1);
        chk("t1_s_adr", ra.s_adr, 32'h1000_0040);
        chk("t1_s_dat", ra.s_dat_m2s, 32'hCAFE_0001);
        chk("t1_s_we", ra.s_we, 1);
        ra.s_ack = 1'b1;
        #1;
        chk("t1_m_ack", ra.m_ack, 3'b001);
        tick();
        ra.s_ack = 1'b0; ra.m_cyc = '0; ra.m_stb = '0; ra.m_we = '0;
        #1;
        chk("t1_hold_grant", ra.grant, 3'b001);
        chk("t1_drop_s_cyc", ra.s_cyc, 0);
        tick();
        chk("t1_release_grant", ra.grant, 0);
        chk("t1_release_busy", ra.busy, 0);

        // Round-robin rotation after reset (pointer was 1 before this reset)
        rst = 1'b1;
        tick();
        rst = 1'b0;
        ra.m_cyc = 3'b111; ra.m_stb = 3'b111;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("t2_grant", ra.grant, exp_g[k]);
            ra.s_ack = 1'b1;
            #1;
            chk("t2_m_ack", ra.m_ack, exp_g[k]);
            tick();
            ra.s_ack = 1'b0;
            ra.m_cyc = 3'b111 & ~exp_g[k];
            ra.m_stb = 3'b111 & ~exp_g[k];
            tick();
            chk("t2_idle_gap", ra.grant, 0);
            ra.m_cyc = 3'b111; ra.m_stb = 3'b111;
        end
        ra.m_cyc = '0; ra.m_stb = '0;
        tick();

        // Burst lock: master0 4-beat burst while master2 waits (pointer now 1)
        ra.m_cyc = 3'b001; ra.m_stb = 3'b001;
        tick();
        chk("t3_grant0", ra.grant, 3'b001);
        ra.m_cyc = 3'b101; ra.m_stb = 3'b101;
        for (int b = 0; b < 4; b++) begin
            ra.m_cti[0] = cti_seq[b];
            ra.s_ack = 1'b1;
            #1;
            chk("t3_m_ack", ra.m_ack, 3'b001);
            chk("t3_s_cti", ra.s_cti, cti_seq[b]);
            tick();
            chk("t3_hold", ra.grant, 3'b001);
        end
        ra.s_ack = 1'b0; ra.m_cyc = 3'b100; ra.m_stb = 3'b100; ra.m_cti[0] = CTI_CLASSIC;
        tick();
        chk("t3_idle", ra.grant, 0);
        tick();
        chk("t3_grant2", ra.grant, 3'b100);

        // Reset mid-burst with master2 owning the bus
        ra.m_cti[2] = CTI_INCR;
        rst = 1'b1;
        tick();
        chk("t4_grant", ra.grant, 0);
        chk("t4_s_cyc", ra.s_cyc, 0);
        chk("t4_busy", ra.busy, 0);
        chk("t4_m_ack", ra.m_ack, 0);
        tick();
        chk("t4_held_rst", ra.grant, 0);
        rst = 1'b0;
        ra.m_cyc = 3'b111; ra.m_stb = 3'b111;
        tick();
        chk("t4_regrant", ra.grant, 3'b001);
        ra.m_cyc = 3'b000; ra.m_stb = 3'b000; ra.m_cti[2] = CTI_CLASSIC;
        tick();
        chk("t4_release", ra.grant, 0);

        // Hung slave: master2 wins from pointer 1, master0 waits
        ra.m_cyc = 3'b101; ra.m_stb = 3'b101;
        tick();
        chk("t5_grant", ra.grant, 3'b100);
`ifdef WB_ARB_TIMEOUT_EN
        for (int c = 1; c < 8; c++) begin
            chk("t5_no_err", ra.m_err, 0);
            chk("t5_s_cyc", ra.s_cyc, 1);
            tick();
        end
        chk("t5_err_pulse", ra.m_err, 3'b100);
        chk("t5_forced_s_cyc", ra.s_cyc, 0);
        tick();
        chk("t5_to_idle", ra.grant, 0);
        chk("t5_err_once", ra.m_err, 0);
        ra.s_ack = 1'b1;
        #1;
        chk("t5_late_ack", ra.m_ack, 0);
        ra.s_ack = 1'b0;
        tick();
        chk("t5_regrant", ra.grant, 3'b001);
`else
        for (int c = 0; c < 12; c++) begin
            chk("t5_hung_grant", ra.grant, 3'b100);
            chk("t5_hung_err", ra.m_err, 0);
            tick();
        end
        chk("t5_hung_s_cyc", ra.s_cyc, 1);
`endif
        ra.m_cyc = '0; ra.m_stb = '0;
        tick();
        tick();

        // Fixed priority: master1 beats master2 every time
        fx.m_cyc = 3'b110; fx.m_stb = 3'b110;
        tick();
        chk("t6_grant", fx.grant, 3'b010);
        fx.s_ack = 1'b1;
        #1;
        chk("t6_m_ack", fx.m_ack, 3'b010);
        fx.s_ack = 1'b0;
        for (int r = 0; r < 2; r++) begin
            fx.m_cyc = 3'b100; fx.m_stb = 3'b100;
            tick();
            chk("t6_idle", fx.grant, 0);
            fx.m_cyc = 3'b110; fx.m_stb = 3'b110;
            tick();
            chk("t6_starve", fx.grant, 3'b010);
        end
        fx.m_cyc = '0; fx.m_stb = '0;
        tick();
        chk("t6_release", fx.grant, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
